// File: rtl/rpn_stack_calc_if.sv
// Command/status bundle for rpn_stack_calc.
//   master : drives in_valid, push, op, d; observes in_ready, out, cnt, err
//   slave  : the calculator side (mirror of master)
interface rpn_stack_calc_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1000
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic             push;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    cnt;
  logic [1:0]       err;

  modport master (
    output in_valid, push, op, d,
    input  in_ready, out, cnt, err
  );

  modport slave (
    input  in_valid, push, op, d,
    output in_ready, out, cnt, err
  );
endinterface

// File: rtl/rpn_stack_calc.sv
// Reverse-Polish stack calculator.
//   step : clock, all state changes on its rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of rpn_stack_calc_if
//          in_valid/in_ready handshake, push/op/d command,
//          out = top of stack (0 when empty), cnt = entries, err = sticky
//          {overflow, underflow}
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting commands; all ops except MUL finish in one edge
// MULT  | shift-add multiply in progress, one partial product per edge
module rpn_stack_calc #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1000
) (
  input logic              step,
  input logic              rst,
  rpn_stack_calc_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_NEG  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_POP  = 3'd7;

  typedef enum logic {IDLE = 1'b0, MULT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [1:0]       err_q;

  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [TW-1:0]    tmr;

  logic [AW-1:0]    t_ptr, s_ptr, n_ptr;
  logic [WIDTH-1:0] top, sec;
  logic             has1, has2, full;

  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_idx, wr1_idx;
  logic [WIDTH-1:0] wr0_data, wr1_data;
  logic [CW-1:0]    cnt_nxt;
  logic [1:0]       err_set;
  logic             mul_start, mul_done;
  logic             in_ready;

  // Pointers wrap when cnt is small; every use is gated by has1/has2.
  assign t_ptr = AW'(cnt_q - CW'(1));
  assign s_ptr = AW'(cnt_q - CW'(2));
  assign n_ptr = AW'(cnt_q);
  assign top   = mem[t_ptr];
  assign sec   = mem[s_ptr];
  assign has1  = (cnt_q != '0);
  assign has2  = (cnt_q > CW'(1));
  assign full  = (cnt_q == FULL);

  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign mul_done = (state == MULT) && (tmr == '0);

  always_comb begin
    wr0_en    = 1'b0;
    wr0_idx   = t_ptr;
    wr0_data  = '0;
    wr1_en    = 1'b0;
    wr1_idx   = s_ptr;
    wr1_data  = '0;
    cnt_nxt   = cnt_q;
    err_set   = 2'b00;
    mul_start = 1'b0;
    if (state == IDLE && bus.in_valid) begin
      if (bus.push) begin
        if (full) begin
          err_set[1] = 1'b1;
        end else begin
          wr0_en   = 1'b1;
          wr0_idx  = n_ptr;
          wr0_data = bus.d;
          cnt_nxt  = cnt_q + CW'(1);
        end
      end else begin
        case (bus.op)
          OP_NOP: ;
          OP_NEG: begin
            if (has1) begin
              wr0_en   = 1'b1;
              wr0_data = '0 - top;
            end else begin
              err_set[0] = 1'b1;
            end
          end
          OP_ADD, OP_SUB: begin
            if (has2) begin
              wr0_en   = 1'b1;
              wr0_idx  = s_ptr;
              wr0_data = (bus.op == OP_ADD) ? (sec + top) : (sec - top);
              cnt_nxt  = cnt_q - CW'(1);
            end else begin
              err_set[0] = 1'b1;
            end
          end
          OP_MUL: begin
            if (has2) mul_start = 1'b1;
            else      err_set[0] = 1'b1;
          end
          OP_DUP: begin
            if (!has1) begin
              err_set[0] = 1'b1;
            end else if (full) begin
              err_set[1] = 1'b1;
            end else begin
              wr0_en   = 1'b1;
              wr0_idx  = n_ptr;
              wr0_data = top;
              cnt_nxt  = cnt_q + CW'(1);
            end
          end
          OP_SWAP: begin
            if (has2) begin
              wr0_en   = 1'b1;
              wr0_data = sec;
              wr1_en   = 1'b1;
              wr1_data = top;
            end else begin
              err_set[0] = 1'b1;
            end
          end
          OP_POP: begin
            if (has1) cnt_nxt = cnt_q - CW'(1);
            else      err_set[0] = 1'b1;
          end
          default: ;
        endcase
      end
    end else if (mul_done) begin
      wr0_en   = 1'b1;
      wr0_idx  = s_ptr;
      wr0_data = acc_nxt;
      cnt_nxt  = cnt_q - CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (mul_start) state_nxt = MULT;
      end
      MULT: begin
        if (tmr == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge step) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge step) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 2'b00;
    end else begin
      cnt_q <= cnt_nxt;
      err_q <= err_q | err_set;
    end
  end

  // Storage has no reset; entries above cnt are never observed.
  always_ff @(posedge step) begin
    if (!rst) begin
      if (wr0_en) mem[wr0_idx] <= wr0_data;
      if (wr1_en) mem[wr1_idx] <= wr1_data;
    end
  end

  // Multiplier: T is consumed LSB first while S is shifted left; the
  // last partial product is folded straight into the write-back.
  always_ff @(posedge step) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      tmr    <= '0;
    end else if (mul_start) begin
      mcand  <= sec;
      mplier <= top;
      acc    <= '0;
      tmr    <= TW'(WIDTH - 1);
    end else if (state == MULT) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      tmr    <= tmr - TW'(1);
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.out      = has1 ? top : '0;
  assign bus.cnt      = cnt_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_rpn_stack_calc.sv
module tb_rpn_stack_calc;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  localparam logic [2:0] NOP = 3'd0, NEG = 3'd1, ADD = 3'd2, MUL = 3'd3;
  localparam logic [2:0] SUB = 3'd4, DUP = 3'd5, SWP = 3'd6, POP = 3'd7;

  logic step;
  logic rst;

  rpn_stack_calc_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rpn_stack_calc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .step (step),
    .rst  (rst),
    .bus  (bus.slave)
  );

  initial begin
    step = 1'b0;
    forever #5 step = ~step;
  end

  typedef struct {
    logic        r;
    logic        v;
    logic        p;
    logic [2:0]  o;
    logic [15:0] d;
    logic [15:0] e_out;
    logic [2:0]  e_cnt;
    logic [1:0]  e_err;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_chk;
  int   n_fail;

  function automatic vec_t mk(logic r, logic v, logic p, logic [2:0] o,
                              logic [15:0] d, logic [15:0] eo,
                              logic [2:0] ec, logic [1:0] ee, logic er);
    vec_t t;
    t.r = r; t.v = v; t.p = p; t.o = o; t.d = d;
    t.e_out = eo; t.e_cnt = ec; t.e_err = ee; t.e_rdy = er;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [15:0] eo, logic [2:0] ec,
                           logic [1:0] ee, logic er);
    chk({tag, " out"}, 32'(bus.out), 32'(eo));
    chk({tag, " cnt"}, 32'(bus.cnt), 32'(ec));
    chk({tag, " err"}, 32'(bus.err), 32'(ee));
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(er));
  endtask

  // Drive one cycle of inputs at the falling edge, sample 1 ns after the rise.
  task automatic cyc(logic r, logic v, logic p, logic [2:0] o, logic [15:0] d);
    @(negedge step);
    rst          = r;
    bus.in_valid = v;
    bus.push     = p;
    bus.op       = o;
    bus.d        = d;
    @(posedge step);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.push     = 1'b0;
    bus.op       = NOP;
    bus.d        = '0;

    //              r  v  p  op    d        out      cnt ierr  rdy
    vecs.push_back(mk(1, 0, 0, NOP, 16'h0, 16'h0000, 3'd0, 2'b00, 1));
    vecs.push_back(mk(0, 1, 1, NOP, 16'd5, 16'h0005, 3'd1, 2'b00, 1));
    vecs.push_back(mk(0, 1, 1, NOP, 16'd7, 16'h0007, 3'd2, 2'b00, 1));
    vecs.push_back(mk(0, 1, 0, ADD, 16'h0, 16'h000C, 3'd1, 2'b00, 1));
    vecs.push_back(mk(0, 1, 0, NEG, 16'h0, 16'hFFF4, 3'd1, 2'b00, 1));
    vecs.push_back(mk(0, 1, 1, NOP, 16'd3, 16'h0003, 3'd2, 2'b00, 1));
    vecs.push_back(mk(0, 1, 0, SUB, 16'h0, 16'hFFF1, 3'd1, 2'b00, 1));
    vecs.push_back(mk(1, 0, 0, NOP, 16'h0, 16'h0000, 3'd0, 2'b00, 1));
    vecs.push_back(mk(0, 1, 1, NOP, 16'd1, 16'h0001, 3'd1, 2'b00, 1));
    vecs.push_back(mk(0, 1, 1, NOP, 16'd2, 16'h0002, 3'd2, 2'b00, 1));
    vecs.push_back(mk(0, 1, 1, NOP, 16'd3, 16'h0003, 3'd3, 2'b00, 1));
    vecs.push_back(mk(0, 1, 1, NOP, 16'd4, 16'h0004, 3'd4, 2'b00, 1));
    vecs.push_back(mk(0, 1, 1, NOP, 16'd9, 16'h0004, 3'd4, 2'b10, 1));
    vecs.push_back(mk(0, 1, 0, DUP, 16'h0, 16'h0004, 3'd4, 2'b10, 1));
    vecs.push_back(mk(0, 1, 0, NOP, 16'h0, 16'h0004, 3'd4, 2'b10, 1));
    vecs.push_back(mk(0, 0, 1, NOP, 16'd7, 16'h0004, 3'd4, 2'b10, 1));
    vecs.push_back(mk(0, 1, 0, SWP, 16'h0, 16'h0003, 3'd4, 2'b10, 1));
    vecs.push_back(mk(0, 1, 0, POP, 16'h0, 16'h0004, 3'd3, 2'b10, 1));
    vecs.push_back(mk(0, 1, 0, DUP, 16'h0, 16'h0004, 3'd4, 2'b10, 1));
    vecs.push_back(mk(1, 0, 0, NOP, 16'h0, 16'h0000, 3'd0, 2'b00, 1));
    vecs.push_back(mk(0, 1, 0, ADD, 16'h0, 16'h0000, 3'd0, 2'b01, 1));
    vecs.push_back(mk(0, 1, 1, NOP, 16'd2, 16'h0002, 3'd1, 2'b01, 1));
    vecs.push_back(mk(0, 1, 0, SWP, 16'h0, 16'h0002, 3'd1, 2'b01, 1));
    vecs.push_back(mk(0, 1, 0, POP, 16'h0, 16'h0000, 3'd0, 2'b01, 1));
    vecs.push_back(mk(0, 1, 0, POP, 16'h0, 16'h0000, 3'd0, 2'b01, 1));
    vecs.push_back(mk(0, 1, 0, NEG, 16'h0, 16'h0000, 3'd0, 2'b01, 1));
    vecs.push_back(mk(0, 1, 0, MUL, 16'h0, 16'h0000, 3'd0, 2'b01, 1));
    vecs.push_back(mk(0, 1, 1, NOP, 16'd9, 16'h0009, 3'd1, 2'b01, 1));
    vecs.push_back(mk(0, 1, 0, MUL, 16'h0, 16'h0009, 3'd1, 2'b01, 1));
    vecs.push_back(mk(0, 1, 0, DUP, 16'h0, 16'h0009, 3'd2, 2'b01, 1));
    vecs.push_back(mk(0, 1, 0, ADD, 16'h0, 16'h0012, 3'd1, 2'b01, 1));

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].v, vecs[i].p, vecs[i].o, vecs[i].d);
      check_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_cnt,
                vecs[i].e_err, vecs[i].e_rdy);
    end

    // MUL 3 * 0xFFFF: busy for 16 edges, commands offered meanwhile are ignored.
    cyc(1, 0, 0, NOP, 16'h0);
    cyc(0, 1, 1, NOP, 16'd3);
    cyc(0, 1, 1, NOP, 16'hFFFF);
    cyc(0, 1, 0, MUL, 16'h0);
    check_all("mul e0", 16'hFFFF, 3'd2, 2'b00, 0);
    for (int k = 1; k < 16; k++) begin
      cyc(0, 1, 1, NOP, 16'h00AA);
      check_all($sformatf("mul e%0d", k), 16'hFFFF, 3'd2, 2'b00, 0);
    end
    cyc(0, 0, 0, NOP, 16'h0);
    check_all("mul done", 16'hFFFD, 3'd1, 2'b00, 1);
    cyc(0, 1, 1, NOP, 16'd2);
    check_all("mul after push", 16'h0002, 3'd2, 2'b00, 1);

    // MUL 6 * 7 aborted by reset at E0+5; no result may land afterwards.
    cyc(1, 0, 0, NOP, 16'h0);
    cyc(0, 1, 1, NOP, 16'd6);
    cyc(0, 1, 1, NOP, 16'd7);
    cyc(0, 1, 0, MUL, 16'h0);
    for (int k = 1; k < 5; k++) cyc(0, 0, 0, NOP, 16'h0);
    check_all("abort pre", 16'h0007, 3'd2, 2'b00, 0);
    cyc(1, 0, 0, NOP, 16'h0);
    check_all("abort rst", 16'h0000, 3'd0, 2'b00, 1);
    cyc(0, 1, 1, NOP, 16'd8);
    check_all("abort push", 16'h0008, 3'd1, 2'b00, 1);
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, NOP, 16'h0);
    check_all("abort quiet", 16'h0008, 3'd1, 2'b00, 1);

    // A second, non-trivial product: 0x1234 * 0x0011 = 0x13574 -> 0x3574.
    cyc(0, 1, 1, NOP, 16'h1234);
    cyc(0, 1, 1, NOP, 16'h0011);
    cyc(0, 1, 0, MUL, 16'h0);
    for (int k = 1; k <= 16; k++) cyc(0, 0, 0, NOP, 16'h0);
    check_all("mul2", 16'h3574, 3'd2, 2'b00, 1);
    cyc(0, 1, 0, POP, 16'h0);
    check_all("mul2 pop", 16'h0008, 3'd1, 2'b00, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rpn_stack_calc.md
RPN_STACK_CALC -- requirements
Module: rpn_stack_calc

Interface
REQ-001 Parameter WIDTH, default 16, operand and stack-entry width in bits (WIDTH >= 2).
REQ-002 Parameter DEPTH, default 1000, maximum stack entries (DEPTH >= 2).
REQ-003 Derived CW = $clog2(DEPTH+1), width of the entry count.
REQ-004 Port step, input, 1, the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1, reset; one clock, reset synchronous and active-high.
REQ-006 Port in_valid, input, 1, command present this cycle.
REQ-007 Port in_ready, output, 1, block can accept a command this cycle.
REQ-008 Port push, input, 1, command is PUSH d; has priority over op.
REQ-009 Port op, input, 3, opcode when push=0: 0 NOP, 1 NEG, 2 ADD, 3 MUL, 4 SUB, 5 DUP, 6 SWAP, 7 POP.
REQ-010 Port d, input, WIDTH, PUSH operand.
REQ-011 Port out, output, WIDTH, current top of stack; 0 when empty.
REQ-012 Port cnt, output, CW, number of valid entries.
REQ-013 Port err, output, 2, sticky flags: bit0 underflow, bit1 overflow.

Function
REQ-014 A command is accepted on a rising edge of step with in_valid=1, in_ready=1 and rst=0; otherwise no state changes except the MUL sequence.
REQ-015 Notation: T = top, S = second entry, n = cnt before the command; all arithmetic is modulo 2^WIDTH, results truncated to WIDTH bits.
REQ-016 PUSH, n<DEPTH: new top = d, cnt = n+1; n=DEPTH: stack unchanged, err[1] set.
REQ-017 NEG, n>=1: T replaced by 0-T, cnt unchanged.
REQ-018 ADD, n>=2: T and S replaced by one entry S+T, cnt = n-1.
REQ-019 SUB, n>=2: T and S replaced by one entry S-T, cnt = n-1.
REQ-020 DUP: n>=1 and n<DEPTH pushes a copy of T, cnt = n+1; n=0 sets err[0]; n=DEPTH sets err[1]; stack unchanged in both error cases.
REQ-021 SWAP, n>=2: T and S exchanged, cnt unchanged.
REQ-022 POP, n>=1: removes T, cnt = n-1; out shows new top or 0 if now empty.
REQ-023 NOP: no change, no flag.
REQ-024 NEG/POP with n=0, or ADD/SUB/SWAP/MUL with n<2: stack unchanged, err[0] set, no MUL sequence started.
REQ-025 All ops except MUL complete on the accepting edge; out and cnt show the result immediately after that edge; in_ready stays 1.
REQ-026 Control FSM states: IDLE (in_ready=1) and MULT (in_ready=0).
REQ-027 Valid MUL accepted at edge E0: IDLE->MULT; shift-add multiply, one partial-product step per edge.
REQ-028 At edge E0+WIDTH, T and S are replaced by one entry (S*T) mod 2^WIDTH, cnt = n-1, FSM->IDLE, in_ready=1.
REQ-029 During MULT, out, cnt and err hold their pre-MUL values; in_valid is ignored.
REQ-030 Stack storage is a DEPTH x WIDTH array; entries beyond cnt are don't-care and never visible on out.
REQ-031 err bits are sticky and are set only by rejected commands; only rst clears them.

Reset
REQ-032 rst=1 at a rising edge: cnt=0, out=0, err=0, FSM=IDLE, in_ready=1 after that edge; array contents need not be cleared.
REQ-033 rst has priority over any command and aborts an in-progress MUL; no result is written.
REQ-034 All outputs are defined from the first edge with rst=1; no behaviour is specified before it.

Verification (WIDTH=16, DEPTH=4 unless stated)
REQ-035 rst=1 for one edge -> out=0, cnt=0, err=0, in_ready=1.
REQ-036 PUSH 5, PUSH 7, ADD -> out=12, cnt=1; then NEG -> out=0xFFF4, cnt=1; PUSH 3, SUB -> out=0xFFF1.
REQ-037 PUSH 3, PUSH 0xFFFF, MUL -> in_ready=0 for 16 cycles, out=0xFFFF and cnt=2 throughout; after edge E0+16 out=0xFFFD, cnt=1, in_ready=1.
REQ-038 PUSH 1,2,3,4, PUSH 9 -> cnt=4, out=4, err=2'b10; DUP -> still cnt=4, err=2'b10.
REQ-039 After reset, ADD -> cnt=0, out=0, err=2'b01; PUSH 2, SWAP -> out=2, cnt=1; POP -> cnt=0, out=0.
REQ-040 PUSH 6, PUSH 7, MUL, rst=1 at edge E0+5 -> cnt=0, out=0, err=0, in_ready=1; PUSH 8 -> out=8, cnt=1.
